// File: rtl/ifu_line_fill.sv
// ifu_line_fill: fetches a 16-byte line as four 32-bit beats on an icache miss.
// A silent memory response aborts the fill with a single-cycle error strobe.
module ifu_line_fill #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         Clock,
  input  logic         Rst,
  input  logic         MissValid,
  input  logic [31:0]  MissPc,
  output logic         FillBusy,
  output logic         MemReqValid,
  output logic [31:0]  MemReqAddr,
  input  logic         MemReqReady,
  input  logic         MemRspValid,
  input  logic [31:0]  MemRspData,
  output logic [127:0] InsLineOut,
  output logic         InsLineValidOut,
  output logic [27:0]  FillTag,
  output logic         FillError
);
  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;
  // The error fires in the silent cycle whose increment would reach the limit.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  state_t         state_q, state_d;
  logic [27:0]    tag_q, tag_d, otag_q, otag_d;
  logic [1:0]     beat_q, beat_d;
  logic [15:0]    tmo_q, tmo_d;
  logic [127:0]   line_q, line_d, out_q, out_d;
  logic           timeout;
  logic           unused;
  assign unused = ^MissPc[3:0];
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    otag_d  = otag_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    line_d  = line_q;
    out_d   = out_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: if (MissValid) begin
        tag_d   = MissPc[31:4];
        state_d = REQ;
      end
      REQ: if (MemReqReady) begin
        beat_d  = 2'd0;
        tmo_d   = 16'd0;
        state_d = RECV;
      end
      RECV: if (MemRspValid) begin
        line_d[{beat_q, 5'd0} +: 32] = MemRspData;
        beat_d = beat_q + 2'd1;
        tmo_d  = 16'd0;
        if (beat_q == 2'd3) begin
          out_d   = {MemRspData, line_q[95:0]};
          otag_d  = tag_q;
          state_d = DONE;
        end
      end else if (TIMEOUT_CYCLES != 0 && tmo_q == TMO_LAST) begin
        timeout = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      otag_q  <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      line_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      otag_q  <= otag_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      line_q  <= line_d;
      out_q   <= out_d;
    end
  end
  assign FillBusy        = state_q != IDLE;
  assign MemReqValid     = state_q == REQ;
  assign MemReqAddr      = {tag_q, 4'b0000};
  assign InsLineValidOut = state_q == DONE;
  assign InsLineOut      = out_q;
  assign FillTag         = otag_q;
  assign FillError       = timeout;
endmodule

// File: tb/tb_ifu_line_fill.sv
// tb_ifu_line_fill: scoreboard bench for ifu_line_fill (default and 4-cycle timeout instances).
module tb_ifu_line_fill;
  logic Clock = 1'b0, Rst = 1'b1;
  logic miss_valid = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0;
  logic [31:0] miss_pc = '0, rsp_data = '0;
  logic busy, req_valid, line_v, err, t_busy, t_req_valid, t_line_v, t_err;
  logic [31:0] req_addr, t_req_addr;
  logic [127:0] line, t_line;
  logic [27:0] tag, t_tag;
  typedef struct packed {logic [127:0] line; logic [27:0] tag;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, err_cnt = 0, t_err_cnt = 0;
  always #5 Clock = ~Clock;
  ifu_line_fill u_dut (
    .Clock(Clock), .Rst(Rst), .MissValid(miss_valid), .MissPc(miss_pc),
    .FillBusy(busy), .MemReqValid(req_valid), .MemReqAddr(req_addr),
    .MemReqReady(req_ready), .MemRspValid(rsp_valid), .MemRspData(rsp_data),
    .InsLineOut(line), .InsLineValidOut(line_v), .FillTag(tag), .FillError(err)
  );
  ifu_line_fill #(.TIMEOUT_CYCLES(4)) u_tmo (
    .Clock(Clock), .Rst(Rst), .MissValid(miss_valid), .MissPc(miss_pc),
    .FillBusy(t_busy), .MemReqValid(t_req_valid), .MemReqAddr(t_req_addr),
    .MemReqReady(req_ready), .MemRspValid(rsp_valid), .MemRspData(rsp_data),
    .InsLineOut(t_line), .InsLineValidOut(t_line_v), .FillTag(t_tag), .FillError(t_err)
  );
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask
  function automatic logic [31:0] bdat(input logic [31:0] pc, input int k);
    return (32'h11111111 * 32'(k + 1)) ^ (pc == 32'h1238 ? 32'h0 : {pc[15:0], pc[19:4]});
  endfunction
  always @(negedge Clock) begin
    if (!Rst && line_v) begin
      if (exp_q.size() == 0) chk("spurious_line", 1'b1, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("line", line, e.line);
        chk("tag", 128'(tag), 128'(e.tag));
      end
    end
    if (!Rst && err) err_cnt++;
    if (!Rst && t_err) t_err_cnt++;
  end
  task automatic fill(input logic [31:0] pc, input int rdly, input int gap, input bit started, input bit stray);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = bdat(pc, k);
    exp_q.push_back('{l, pc[31:4]});
    if (!started) begin
      miss_valid = 1'b1; miss_pc = pc;
      tick;
      miss_valid = 1'b0;
    end
    chk("busy_req", busy, 1'b1);
    chk("req_addr", 128'(req_addr), 128'({pc[31:4], 4'b0}));
    for (int i = 0; i < rdly; i++) begin
      rsp_valid = 1'b1; rsp_data = 32'hdeadbeef;
      chk("req_valid_hold", req_valid, 1'b1);
      chk("req_addr_hold", 128'(req_addr), 128'({pc[31:4], 4'b0}));
      tick;
    end
    rsp_valid = 1'b0;
    chk("req_valid", req_valid, 1'b1);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rsp_valid = 1'b1; rsp_data = bdat(pc, k);
      if (stray && k == 1) begin miss_valid = 1'b1; miss_pc = 32'h0000_2000; end
      tick;
      rsp_valid = 1'b0; miss_valid = 1'b0;
      if (k < 3) repeat (gap) tick;
    end
    chk("strobe", line_v, 1'b1);
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_req_valid"}, req_valid, 1'b0);
    chk({name, "_req_addr"}, 128'(req_addr), 128'h0);
    chk({name, "_line_v"}, line_v, 1'b0);
    chk({name, "_err"}, err, 1'b0);
    chk({name, "_line"}, line, 128'h0);
    chk({name, "_tag"}, 128'(tag), 128'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (2) tick;
    chk_zero("rst");
    Rst = 1'b0;
    fill(32'h0000_1238, 0, 0, 0, 0);
    chk("addr_34", 128'(req_addr), 128'h1230);
    chk("line_34", line, 128'h44444444_33333333_22222222_11111111);
    chk("tag_34", 128'(tag), 128'h0000123);
    tick;
    chk("busy_t7", busy, 1'b0);
    chk("hold_line", line, 128'h44444444_33333333_22222222_11111111);
    fill(32'h0000_8004, 5, 0, 0, 0);
    tick;
    fill(32'h0abc_def0, 0, 3, 0, 0);
    tick;
    rsp_valid = 1'b1; rsp_data = 32'hffff_ffff;
    tick;
    rsp_valid = 1'b0;
    chk("stray_idle_busy", busy, 1'b0);
    fill(32'h0000_4440, 0, 0, 0, 1);
    miss_valid = 1'b1; miss_pc = 32'h0000_5550;
    tick;
    chk("done_miss_ignored", busy, 1'b0);
    tick;
    miss_valid = 1'b0;
    fill(32'h0000_5550, 1, 0, 1, 0);
    tick;
    miss_valid = 1'b1; miss_pc = 32'h0000_7770;
    tick;
    miss_valid = 1'b0; req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rsp_valid = 1'b1; rsp_data = bdat(32'h7770, k);
      tick;
    end
    rsp_valid = 1'b0;
    n = 0;
    while (!t_err && n < 20) begin
      chk("tmo_no_line", t_line_v, 1'b0);
      tick;
      n++;
    end
    chk("tmo_latency", 128'(n), 128'd3);
    chk("tmo_err", t_err, 1'b1);
    chk("tmo_line_v", t_line_v, 1'b0);
    tick;
    chk("tmo_busy", t_busy, 1'b0);
    chk("tmo_err_pulse", t_err, 1'b0);
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    miss_valid = 1'b1; miss_pc = 32'h0000_3000;
    tick;
    miss_valid = 1'b0; req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rsp_valid = 1'b1; rsp_data = bdat(32'h3000, k);
      tick;
    end
    rsp_valid = 1'b0; Rst = 1'b1;
    tick;
    Rst = 1'b0;
    chk_zero("mid_rst");
    rsp_valid = 1'b1; rsp_data = bdat(32'h3000, 3);
    tick;
    rsp_valid = 1'b0;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_line_v", line_v, 1'b0);
    fill(32'h0000_9990, 0, 0, 0, 0);
    tick;
    chk("err_cnt", 128'(err_cnt), 128'd0);
    chk("t_err_cnt", 128'(t_err_cnt), 128'd1);
    chk("sb_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ifu_line_fill.md
IFU_LINE_FILL -- requirements
Module: ifu_line_fill

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max consecutive RECV cycles without a response beat; legal range 0..65535, 0 = timeout disabled.
REQ-002 Clock  input  1  SHALL be the rising-edge clock for all state.
REQ-003 Rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 MissValid  input  1  SHALL flag an instruction-cache miss.
REQ-005 MissPc  input  32  SHALL be the missing fetch PC.
REQ-006 FillBusy  output  1  SHALL be high while a fill is in progress.
REQ-007 MemReqValid  output  1  SHALL flag a line read request to memory.
REQ-008 MemReqAddr  output  32  SHALL be the line-aligned request address.
REQ-009 MemReqReady  input  1  SHALL be memory's request acceptance.
REQ-010 MemRspValid  input  1  SHALL flag one 32-bit response beat.
REQ-011 MemRspData  input  32  SHALL be the response beat data.
REQ-012 InsLineOut  output  128  SHALL be the assembled 16-byte line to the cache.
REQ-013 InsLineValidOut  output  1  SHALL be the single-cycle line-valid strobe to the cache.
REQ-014 FillTag  output  28  SHALL be MissPc[31:4] of the delivered line.
REQ-015 FillError  output  1  SHALL be the single-cycle timeout error strobe.

Function
REQ-016 FSM states SHALL be IDLE, REQ, RECV, DONE; FillBusy SHALL equal (state != IDLE).
REQ-017 IDLE: MissValid=1 SHALL latch MissPc[31:4] into the tag register and move to REQ next cycle.
REQ-018 MissValid outside IDLE SHALL be ignored; no queueing, the cache re-asserts after FillBusy drops.
REQ-019 REQ: MemReqValid SHALL be 1 and MemReqAddr SHALL be {tag,4'b0000}, both stable until MemReqReady=1.
REQ-020 REQ with MemReqReady=1 SHALL move to RECV, clearing the beat counter (2 bits) and the timeout counter (16 bits).
REQ-021 RECV: each MemRspValid=1 cycle SHALL write MemRspData into line bits [32k+31:32k], k = beat counter, then increment k.
REQ-022 Beat k=3 accepted SHALL move to DONE next cycle; beat 0 is the lowest word.
REQ-023 MemRspValid in IDLE, REQ or DONE SHALL be ignored with no state change.
REQ-024 RECV with MemRspValid=0 SHALL increment the timeout counter; a beat SHALL clear it.
REQ-025 With TIMEOUT_CYCLES != 0, timeout counter reaching TIMEOUT_CYCLES SHALL pulse FillError for one cycle, return to IDLE, and deliver no line.
REQ-026 DONE: InsLineValidOut SHALL be 1 for exactly one cycle with InsLineOut and FillTag valid, then return to IDLE.
REQ-027 InsLineOut and FillTag SHALL be registered and hold until the next DONE.
REQ-028 Latency: MissValid at t, MemReqReady at t+1, beats at t+2..t+5 SHALL give InsLineValidOut at t+6 and FillBusy low at t+7.
REQ-029 A partial line SHALL never be presented with InsLineValidOut=1.
REQ-030 MissValid in the DONE cycle SHALL be ignored; MissValid in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-031 Rst=1 SHALL force state IDLE, counters 0, and FillBusy, MemReqValid, InsLineValidOut, FillError = 0, MemReqAddr = 0, InsLineOut = 0, FillTag = 0.
REQ-032 Rst during REQ/RECV/DONE SHALL abandon the fill with no InsLineValidOut; beats arriving after reset SHALL be ignored.
REQ-033 Rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-034 MissPc=0x0000_1238, Ready immediate, beats 0x11111111,0x22222222,0x33333333,0x44444444 back-to-back -> MemReqAddr=0x0000_1230; InsLineOut=0x44444444_33333333_22222222_11111111, FillTag=0x0000123, strobe at t+6.
REQ-035 MemReqReady held low 5 cycles -> MemReqValid and MemReqAddr stable for 6 cycles; no beat accepted before Ready.
REQ-036 Beats with 3 idle gaps between each, TIMEOUT_CYCLES=255 -> line assembled correctly, FillError=0.
REQ-037 TIMEOUT_CYCLES=4, only 2 beats sent -> FillError pulse 4 cycles after the last beat, InsLineValidOut never 1, FillBusy=0 next cycle.
REQ-038 Second MissValid (0x0000_2000) during RECV, plus stray MemRspValid in IDLE -> second miss ignored, first line delivered intact, stray beat no effect.
REQ-039 Rst after beat 2 -> all outputs 0 next cycle; remaining beats ignored; new miss then completes normally.
